// File: rtl/regfile_pkg.sv
// Shared types and widths for the vector register-file read engine.
package regfile_pkg;

  localparam int WORD_SIZE  = 32;
  localparam int WORDS      = 16;
  localparam int NO_OF_ELEM = 16;
  localparam int ADDR_W     = $clog2(NO_OF_ELEM);
  localparam int CNT_W      = ADDR_W + 1;
  localparam int IDX_W      = $clog2(WORDS);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    STREAM,
    DONE
  } rd_state_t;

endpackage

// File: rtl/regfile_stream_reader_entry_serializer.sv
// Parallel-load entry buffer that emits one word per valid/ready handshake, LSW first.
module entry_serializer
  import regfile_pkg::*;
#(
  parameter int wordSize = WORD_SIZE,
  parameter int words    = WORDS
) (
  input  logic                      clk,
  input  logic                      RESET,
  input  logic                      load,
  input  logic [words*wordSize-1:0] loadData,
  input  logic                      m_ready,
  output logic                      m_valid,
  output logic [wordSize-1:0]       m_data,
  output logic                      lastWord,
  output logic                      wordDone
);

  logic [words*wordSize-1:0] entryBuf;
  logic [IDX_W-1:0]          idx;
  logic                      validReg;

  // Valid is a register so it never depends combinationally on m_ready.
  always_ff @(posedge clk or negedge RESET) begin
    if (!RESET) begin
      entryBuf <= '0;
      idx      <= '0;
      validReg <= 1'b0;
    end else if (load) begin
      entryBuf <= loadData;
      idx      <= '0;
      validReg <= 1'b1;
    end else if (validReg && m_ready) begin
      if (lastWord) begin
        idx      <= '0;
        validReg <= 1'b0;
      end else begin
        idx <= idx + IDX_W'(1);
      end
    end
  end

  assign lastWord = (idx == IDX_W'(words - 1));
  assign wordDone = validReg && m_ready && lastWord;
  assign m_valid  = validReg;
  assign m_data   = entryBuf[idx*wordSize +: wordSize];

endmodule

// File: rtl/regfile_stream_reader.sv
// Walks consecutive register-file entries and streams each one out word by word.
module regfile_stream_reader
  import regfile_pkg::*;
#(
  parameter int wordSize = WORD_SIZE,
  parameter int words    = WORDS,
  parameter int NoOfElem = NO_OF_ELEM
) (
  input  logic                      clk,
  input  logic                      RESET,
  input  logic [words*wordSize-1:0] regData [0:NoOfElem-1],
  input  logic                      start,
  input  logic [ADDR_W-1:0]         startAddr,
  input  logic [CNT_W-1:0]          numElem,
  output logic                      busy,
  output logic                      done,
  output logic [ADDR_W-1:0]         curAddr,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [wordSize-1:0]       m_data,
  output logic                      m_last
);

  rd_state_t        state, nextState;
  logic [CNT_W-1:0] remaining;
  logic             load;
  logic             lastWord;
  logic             wordDone;

  always_ff @(posedge clk or negedge RESET) begin
    if (!RESET) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Address wraps for free because NoOfElem is a power of two.
  always_ff @(posedge clk or negedge RESET) begin
    if (!RESET) begin
      curAddr   <= '0;
      remaining <= '0;
    end else if (state == IDLE && start && numElem != '0) begin
      curAddr   <= startAddr;
      remaining <= numElem;
    end else if (state == STREAM && wordDone && remaining > CNT_W'(1)) begin
      curAddr   <= curAddr + ADDR_W'(1);
      remaining <= remaining - CNT_W'(1);
    end
  end

  always_comb begin
    nextState = state;
    load      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          nextState = (numElem == '0) ? DONE : LOAD;
        end
      end
      LOAD: begin
        load      = 1'b1;
        nextState = STREAM;
      end
      STREAM: begin
        if (wordDone) begin
          nextState = (remaining > CNT_W'(1)) ? LOAD : DONE;
        end
      end
      DONE: begin
        nextState = IDLE;
      end
      default: begin
        nextState = IDLE;
      end
    endcase
  end

  entry_serializer #(
    .wordSize(wordSize),
    .words   (words)
  ) serializer (
    .clk     (clk),
    .RESET   (RESET),
    .load    (load),
    .loadData(regData[curAddr]),
    .m_ready (m_ready),
    .m_valid (m_valid),
    .m_data  (m_data),
    .lastWord(lastWord),
    .wordDone(wordDone)
  );

  assign busy   = (state != IDLE);
  assign done   = (state == DONE);
  assign m_last = m_valid && lastWord && (remaining == CNT_W'(1));

endmodule

// File: tb/tb_regfile_stream_reader.sv
// Directed bench for regfile_stream_reader with a word-queue reference model.
module tb_regfile_stream_reader;

  localparam int WS = 32;
  localparam int NW = 16;
  localparam int NE = 16;

  logic           clk;
  logic           RESET;
  logic [NW*WS-1:0] regData [0:NE-1];
  logic           start;
  logic [3:0]     startAddr;
  logic [4:0]     numElem;
  logic           busy;
  logic           done;
  logic [3:0]     curAddr;
  logic           m_valid;
  logic           m_ready;
  logic [WS-1:0]  m_data;
  logic           m_last;

  int checks;
  int failures;
  int wordCount;
  int doneCount;
  int cyc;
  int w0;
  int d0;
  logic bpEnable;

  logic [WS-1:0] expData [$];
  logic          expLast [$];

  logic          prevStall;
  logic [WS-1:0] prevData;
  logic          prevLast;

  regfile_stream_reader #(.wordSize(WS), .words(NW), .NoOfElem(NE)) dut (
    .clk      (clk),
    .RESET    (RESET),
    .regData  (regData),
    .start    (start),
    .startAddr(startAddr),
    .numElem  (numElem),
    .busy     (busy),
    .done     (done),
    .curAddr  (curAddr),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_data   (m_data),
    .m_last   (m_last)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Expected stream is the whole command expanded into words when it is issued.
  task automatic applyStimulus(input int addr, input int n);
    @(posedge clk);
    #1;
    start     = 1'b1;
    startAddr = 4'(addr);
    numElem   = 5'(n);
    for (int i = 0; i < n; i++) begin
      int a;
      a = (addr + i) % NE;
      for (int w = 0; w < NW; w++) begin
        expData.push_back(regData[a][w*WS +: WS]);
        expLast.push_back((i == n - 1) && (w == NW - 1));
      end
    end
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic waitDone(input int startCount, input int maxCycles, output int cycles);
    cycles = startCount;
    while (!done && cycles < maxCycles) begin
      @(posedge clk);
      #1;
      cycles++;
    end
    if (!done) begin
      checkOutput("doneTimeout", 64'd0, 64'd1);
    end else begin
      @(posedge clk);
      #1;
      checkOutput("donePulseWidth", 64'(done), 64'd0);
      checkOutput("idleAfterDone", 64'(busy), 64'd0);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (bpEnable) m_ready = 1'($urandom_range(0, 1));
    end
  end

  // Compare process: every valid cycle is checked against the head of the queue.
  initial begin
    prevStall = 1'b0;
    prevData  = '0;
    prevLast  = 1'b0;
    forever begin
      @(negedge clk);
      if (!RESET) begin
        prevStall = 1'b0;
      end else begin
        if (done) doneCount++;
        if (prevStall) begin
          checkOutput("stallValidHeld", 64'(m_valid), 64'd1);
          checkOutput("stallDataHeld", 64'(m_data), 64'(prevData));
          checkOutput("stallLastHeld", 64'(m_last), 64'(prevLast));
        end
        if (m_valid) begin
          if (expData.size() == 0) begin
            checkOutput("unexpectedWord", 64'd1, 64'd0);
          end else begin
            checkOutput("streamData", 64'(m_data), 64'(expData[0]));
            checkOutput("streamLast", 64'(m_last), 64'(expLast[0]));
            if (m_ready) begin
              void'(expData.pop_front());
              void'(expLast.pop_front());
              wordCount++;
            end
          end
        end else begin
          checkOutput("lastWithoutValid", 64'(m_last), 64'd0);
        end
        prevStall = m_valid && !m_ready;
        prevData  = m_data;
        prevLast  = m_last;
      end
    end
  end

  initial begin
    checks    = 0;
    failures  = 0;
    wordCount = 0;
    doneCount = 0;
    bpEnable  = 1'b0;
    RESET     = 1'b0;
    start     = 1'b0;
    startAddr = '0;
    numElem   = '0;
    m_ready   = 1'b1;
    for (int e = 0; e < NE; e++)
      for (int w = 0; w < NW; w++)
        regData[e][w*WS +: WS] = WS'(e * 256 + w);

    #22;
    checkOutput("resetBusy", 64'(busy), 64'd0);
    checkOutput("resetDone", 64'(done), 64'd0);
    checkOutput("resetValid", 64'(m_valid), 64'd0);
    checkOutput("resetLast", 64'(m_last), 64'd0);
    checkOutput("resetData", 64'(m_data), 64'd0);
    checkOutput("resetAddr", 64'(curAddr), 64'd0);
    @(posedge clk);
    #1;
    RESET = 1'b1;

    $display("[TB] single entry");
    w0 = wordCount;
    applyStimulus(3, 1);
    checkOutput("loadBubbleValid", 64'(m_valid), 64'd0);
    checkOutput("loadBusy", 64'(busy), 64'd1);
    checkOutput("loadAddr", 64'(curAddr), 64'd3);
    @(posedge clk);
    #1;
    checkOutput("firstValid", 64'(m_valid), 64'd1);
    checkOutput("firstWord", 64'(m_data), 64'h300);
    waitDone(1, 100, cyc);
    checkOutput("singleLatency", 64'(cyc), 64'd17);
    checkOutput("singleWords", 64'(wordCount - w0), 64'd16);
    checkOutput("singleDrained", 64'(expData.size()), 64'd0);

    $display("[TB] wrap-around");
    applyStimulus(15, 2);
    checkOutput("wrapStartAddr", 64'(curAddr), 64'd15);
    repeat (17) begin
      @(posedge clk);
      #1;
    end
    checkOutput("wrapBubble", 64'(m_valid), 64'd0);
    checkOutput("wrapAddr", 64'(curAddr), 64'd0);
    checkOutput("wrapBusy", 64'(busy), 64'd1);
    waitDone(17, 200, cyc);
    checkOutput("wrapLatency", 64'(cyc), 64'd34);
    checkOutput("wrapDrained", 64'(expData.size()), 64'd0);

    $display("[TB] backpressure");
    bpEnable = 1'b1;
    applyStimulus(6, 3);
    waitDone(0, 2000, cyc);
    bpEnable = 1'b0;
    @(posedge clk);
    #2;
    m_ready = 1'b1;
    checkOutput("bpNotFaster", 64'(cyc >= 51), 64'd1);
    checkOutput("bpDrained", 64'(expData.size()), 64'd0);

    $display("[TB] snapshot");
    applyStimulus(5, 1);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    for (int w = 0; w < NW; w++) regData[5][w*WS +: WS] = 32'hBEEF0000 + 32'(w);
    waitDone(2, 100, cyc);
    checkOutput("snapLatency", 64'(cyc), 64'd17);
    applyStimulus(5, 1);
    @(posedge clk);
    #1;
    checkOutput("snapNewFirst", 64'(m_data), 64'hBEEF0000);
    waitDone(1, 100, cyc);
    checkOutput("snapDrained", 64'(expData.size()), 64'd0);

    $display("[TB] zero count");
    w0 = wordCount;
    applyStimulus(4, 0);
    checkOutput("zeroBusy", 64'(busy), 64'd1);
    checkOutput("zeroDone", 64'(done), 64'd1);
    waitDone(0, 10, cyc);
    checkOutput("zeroLatency", 64'(cyc), 64'd0);
    checkOutput("zeroWords", 64'(wordCount - w0), 64'd0);

    $display("[TB] start while busy");
    w0 = wordCount;
    d0 = doneCount;
    applyStimulus(1, 2);
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    start     = 1'b1;
    startAddr = 4'd9;
    numElem   = 5'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    waitDone(6, 200, cyc);
    checkOutput("busyStartLatency", 64'(cyc), 64'd34);
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    checkOutput("busyStartIdle", 64'(busy), 64'd0);
    checkOutput("busyStartWords", 64'(wordCount - w0), 64'd32);
    checkOutput("busyStartDones", 64'(doneCount - d0), 64'd1);

    $display("[TB] reset mid-stream");
    applyStimulus(0, 4);
    repeat (42) begin
      @(posedge clk);
      #1;
    end
    checkOutput("preResetWord", 64'(m_data), 64'h207);
    checkOutput("preResetValid", 64'(m_valid), 64'd1);
    d0 = doneCount;
    RESET = 1'b0;
    expData.delete();
    expLast.delete();
    #1;
    checkOutput("abortValid", 64'(m_valid), 64'd0);
    checkOutput("abortBusy", 64'(busy), 64'd0);
    checkOutput("abortData", 64'(m_data), 64'd0);
    checkOutput("abortAddr", 64'(curAddr), 64'd0);
    checkOutput("abortLast", 64'(m_last), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    RESET = 1'b1;
    checkOutput("abortNoDone", 64'(doneCount - d0), 64'd0);
    applyStimulus(2, 1);
    @(posedge clk);
    #1;
    checkOutput("restartFirst", 64'(m_data), 64'h200);
    waitDone(1, 100, cyc);
    checkOutput("restartLatency", 64'(cyc), 64'd17);
    checkOutput("restartDrained", 64'(expData.size()), 64'd0);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
